keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: drives one column low per slot, debounces each key
// independently and reports press events with the code of the pressed key.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 5
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [3:0] KEY_ROW,
  output logic [2:0] KEY_COL,
  output logic [9:0] KEY,
  output logic       KEY_STAR,
  output logic       KEY_HASH,
  output logic       KEY_PRESS,
  output logic [3:0] KEY_CODE
);

  localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_CNT);

  logic [3:0]  row_meta;
  logic [3:0]  row_sync;
  logic [15:0] div_cnt;
  logic [1:0]  col_idx;
  logic        sample;

  // Debounce state indexed by key code: 0..9 digits, 10 '*', 11 '#'.
  logic [11:0] deb;
  logic [11:0] deb_nxt;
  logic [11:0] rise;
  logic [3:0]  cnt     [12];
  logic [3:0]  cnt_nxt [12];
  logic [3:0]  low_code;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    case (row)
      2'd0:    key_code = 4'd1 + {2'b00, col};
      2'd1:    key_code = 4'd4 + {2'b00, col};
      2'd2:    key_code = 4'd7 + {2'b00, col};
      default: begin
        case (col)
          2'd0:    key_code = 4'd10;
          2'd1:    key_code = 4'd0;
          default: key_code = 4'd11;
        endcase
      end
    endcase
  endfunction

  assign sample  = (div_cnt == DIV_LAST);
  assign KEY_COL = ~(3'b001 << col_idx);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= KEY_ROW;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Only the four keys of the driven column are touched at the end of its slot.
  always_comb begin
    logic [3:0] k;
    logic       raw;
    k       = '0;
    raw     = 1'b0;
    deb_nxt = deb;
    rise    = '0;
    for (int i = 0; i < 12; i++) cnt_nxt[i] = cnt[i];
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        k   = key_code(2'(r), col_idx);
        raw = ~row_sync[r];
        if (raw == deb[k]) begin
          cnt_nxt[k] = '0;
        end else if (cnt[k] + 4'd1 == DEB_TARGET) begin
          deb_nxt[k] = raw;
          cnt_nxt[k] = '0;
          rise[k]    = raw;
        end else begin
          cnt_nxt[k] = cnt[k] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    low_code = '0;
    for (int i = 11; i >= 0; i--) begin
      if (rise[i]) low_code = 4'(i);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      deb       <= '0;
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
      KEY       <= '0;
      KEY_STAR  <= 1'b0;
      KEY_HASH  <= 1'b0;
      KEY_PRESS <= 1'b0;
      KEY_CODE  <= '0;
    end else begin
      deb       <= deb_nxt;
      cnt       <= cnt_nxt;
      KEY       <= deb_nxt[9:0];
      KEY_STAR  <= deb_nxt[10];
      KEY_HASH  <= deb_nxt[11];
      KEY_PRESS <= |rise;
      if (|rise) KEY_CODE <= low_code;
    end
  end

endmodule
